lab4_univ_shift_reg: RTL and testbench
======================================

LAB4_UNIV_SHIFT_REG -- requirements
Module: lab4_univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 4, register width in bits (>=2).
REQ-002 SHALL have parameter NEG_EDGE, default 1; 1 = state updates on falling clock edge, 0 = on rising edge.
REQ-003 SHALL define CW = $clog2(WIDTH+1) as the width of n_shifts.
REQ-004 SHALL have ports, in this order:
- clock  in  1  sole clock.
- reset_b  in  1  asynchronous, active-low reset.
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- rotate  in  1  1 = circular shift; serial inputs ignored.
- ser_in_r  in  1  bit entering the MSB on a right shift.
- ser_in_l  in  1  bit entering the LSB on a left shift.
- par_in  in  WIDTH  parallel load data.
- start  in  1  launches an automatic shift burst.
- n_shifts  in  CW  burst length.
- Q  out  WIDTH  register contents.
- NQ  out  WIDTH  bitwise complement of Q.
- busy  out  1  burst in progress.
- done  out  1  one-cycle burst-complete pulse.

Function
REQ-005 SHALL update all state only on the active edge selected by NEG_EDGE; the other edge SHALL cause no change.
REQ-006 SHALL keep NQ equal to ~Q at all times, with no extra latency.
REQ-007 SHALL implement an FSM with states IDLE, BURST and DONE.
REQ-008 In IDLE, SHALL apply mode at each active edge, with one-edge latency:
- hold: Q unchanged.
- right: Q <= {ser_in_r or Q[0] if rotate, Q[WIDTH-1:1]}.
- left: Q <= {Q[WIDTH-2:0], ser_in_l or Q[WIDTH-1] if rotate}.
- load: Q <= par_in.
REQ-009 In IDLE, SHALL start a burst when start=1, mode is 01 or 10, and n_shifts!=0:
- latch direction, rotate and remaining = min(n_shifts, WIDTH);
- go to BURST;
- leave Q unchanged on that edge.
REQ-010 If start=1 in IDLE with n_shifts=0 or mode 00/11, SHALL perform the normal mode operation and not enter BURST.
REQ-011 In BURST, SHALL at each active edge:
- shift once in the latched direction, using the live ser_in_r/ser_in_l unless rotate was latched;
- decrement remaining;
- go to DONE on the edge where remaining reaches 0.
REQ-012 SHALL ignore mode, par_in and start while in BURST or DONE.
REQ-013 SHALL drive busy=1 exactly in BURST and done=1 exactly in DONE.
REQ-014 DONE SHALL last one cycle and return to IDLE with Q held.
REQ-015 SHALL clamp n_shifts values greater than WIDTH to WIDTH.

Reset
REQ-016 SHALL, while reset_b=0 and regardless of clock, force:
- Q=0 and NQ=all ones;
- state IDLE, remaining=0;
- busy=0, done=0.
REQ-017 Reset asserted mid-burst SHALL abort the burst with no done pulse.
REQ-018 After reset_b rises, operation SHALL resume at the next active edge.

Configuration
REQ-019 With macro LAB4_SHREG_PARITY_EN defined, SHALL add output port parity (1 bit, after done), equal to ^Q with no latency (0 in reset).
REQ-020 Without LAB4_SHREG_PARITY_EN, the parity port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-021 Package lab4_pkg SHALL hold:
- mode typedef/constants MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD;
- FSM state typedef (IDLE, BURST, DONE).
REQ-022 Per-bit storage SHALL be sub-module lab4_shreg_cell: 4:1 next-value mux plus edge-selectable flip-flop with async active-low reset, instantiated WIDTH times.

Verification (WIDTH=4, NEG_EDGE=1)
REQ-023 Reset: reset_b=0 between edges -> Q=0000, NQ=1111, busy=0, done=0 immediately.
REQ-024 Load/edge check: mode=11, par_in=1011 -> Q=1011 after the falling edge; no change on the rising edge.
REQ-025 Shift checks:
- from 1011, mode=01, ser_in_r=1 -> 1101;
- from 1011, mode=10, ser_in_l=0 -> 0110;
- from 1011, rotate=1, mode=01 -> 1101.
REQ-026 Burst: from Q=1000, mode=01, rotate=1, start=1, n_shifts=3 ->
- busy high for 3 edges, with Q 0100, 0010, 0001;
- then done high for 1 cycle;
- then IDLE.
REQ-027 Burst abort: reset_b=0 after the 2nd burst shift -> Q=0000, busy=0, no done pulse.
REQ-028 Edge cases:
- start=1, n_shifts=0, mode=11 -> load only, busy stays 0;
- n_shifts=6 -> exactly 4 shifts;
- with LAB4_SHREG_PARITY_EN, Q=1011 -> parity=1.

Source files
------------

// File: rtl/lab4_pkg.sv
// rtl/lab4_pkg.sv - shared mode and FSM state encodings for the universal shift register
package lab4_pkg;

  typedef logic [1:0] mode_t;
  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BURST = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  function automatic logic is_shift(input mode_t m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/lab4_univ_shift_reg_if.sv
// rtl/lab4_univ_shift_reg_if.sv - control bundle (mode, burst request, burst status)
interface lab4_univ_shift_reg_if #(
  parameter int WIDTH = 4
);
  import lab4_pkg::*;
  localparam int CW = $clog2(WIDTH + 1);

  mode_t           mode;
  logic            rotate;
  logic            start;
  logic [CW-1:0]   n_shifts;
  logic            busy;
  logic            done;

  modport master (output mode, rotate, start, n_shifts, input busy, done);
  modport slave  (input mode, rotate, start, n_shifts, output busy, done);
endinterface

// File: rtl/lab4_shreg_cell.sv
// rtl/lab4_shreg_cell.sv - one register bit: 4:1 next-value mux and edge-selectable flop
module lab4_shreg_cell
  import lab4_pkg::*;
#(
  parameter int NEG_EDGE = 1
) (
  input  logic  clock,
  input  logic  reset_b,
  input  mode_t sel,
  input  logic  shr_in,
  input  logic  shl_in,
  input  logic  load_in,
  output logic  q
);

  logic clk_act;
  logic q_d;
  logic q_q;

  // Inverting the clock lets the same posedge flop serve both edge choices.
  assign clk_act = (NEG_EDGE != 0) ? ~clock : clock;

  always_comb begin
    q_d = q_q;
    case (sel)
      MODE_SHR:  q_d = shr_in;
      MODE_SHL:  q_d = shl_in;
      MODE_LOAD: q_d = load_in;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk_act or negedge reset_b) begin
    if (!reset_b) q_q <= 1'b0;
    else          q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/lab4_univ_shift_reg_ctrl.sv
// rtl/lab4_univ_shift_reg_ctrl.sv - IDLE/BURST/DONE sequencer choosing the per-cell operation
module lab4_univ_shift_reg_ctrl
  import lab4_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int NEG_EDGE = 1
) (
  input  logic                    clock,
  input  logic                    reset_b,
  lab4_univ_shift_reg_if.slave    ctl,
  output mode_t                   cell_sel,
  output logic                    rot_eff
);

  localparam int            CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] N_MAX = CW'(WIDTH);

  logic          clk_act;
  state_t        state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  mode_t         dir_q, dir_d;
  logic          rot_q, rot_d;

  assign clk_act = (NEG_EDGE != 0) ? ~clock : clock;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    rot_d    = rot_q;
    cell_sel = MODE_HOLD;
    rot_eff  = rot_q;
    case (state_q)
      ST_IDLE: begin
        cell_sel = ctl.mode;
        rot_eff  = ctl.rotate;
        if (ctl.start && is_shift(ctl.mode) && (ctl.n_shifts != '0)) begin
          cell_sel = MODE_HOLD;
          dir_d    = ctl.mode;
          rot_d    = ctl.rotate;
          rem_d    = (ctl.n_shifts > N_MAX) ? N_MAX : ctl.n_shifts;
          state_d  = ST_BURST;
        end
      end
      ST_BURST: begin
        cell_sel = dir_q;
        rem_d    = rem_q - CW'(1);
        if (rem_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_act or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      dir_q   <= MODE_HOLD;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
    end
  end

  assign ctl.busy = (state_q == ST_BURST);
  assign ctl.done = (state_q == ST_DONE);

endmodule

// File: rtl/lab4_univ_shift_reg.sv
// rtl/lab4_univ_shift_reg.sv - universal shift register with auto-shift burst; LAB4_SHREG_PARITY_EN adds parity output
module lab4_univ_shift_reg
  import lab4_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int NEG_EDGE = 1,
  localparam int CW      = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic [CW-1:0]    n_shifts,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] NQ,
  output logic             busy,
  output logic             done
`ifdef LAB4_SHREG_PARITY_EN
  ,output logic            parity
`endif
);

  lab4_univ_shift_reg_if #(.WIDTH(WIDTH)) ctl_if ();

  mode_t            cell_sel;
  logic             rot_eff;
  logic [WIDTH-1:0] q_vec;
  logic [WIDTH-1:0] shr_vec;
  logic [WIDTH-1:0] shl_vec;

  assign ctl_if.mode     = mode;
  assign ctl_if.rotate   = rotate;
  assign ctl_if.start    = start;
  assign ctl_if.n_shifts = n_shifts;
  assign busy            = ctl_if.busy;
  assign done            = ctl_if.done;

  lab4_univ_shift_reg_ctrl #(.WIDTH(WIDTH), .NEG_EDGE(NEG_EDGE)) u_ctrl (
    .clock    (clock),
    .reset_b  (reset_b),
    .ctl      (ctl_if),
    .cell_sel (cell_sel),
    .rot_eff  (rot_eff)
  );

  // Rotation feeds the bit falling off the far end back in place of the serial input.
  assign shr_vec = {(rot_eff ? q_vec[0] : ser_in_r), q_vec[WIDTH-1:1]};
  assign shl_vec = {q_vec[WIDTH-2:0], (rot_eff ? q_vec[WIDTH-1] : ser_in_l)};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    lab4_shreg_cell #(.NEG_EDGE(NEG_EDGE)) u_cell (
      .clock   (clock),
      .reset_b (reset_b),
      .sel     (cell_sel),
      .shr_in  (shr_vec[i]),
      .shl_in  (shl_vec[i]),
      .load_in (par_in[i]),
      .q       (q_vec[i])
    );
  end

  assign Q  = q_vec;
  assign NQ = ~q_vec;

`ifdef LAB4_SHREG_PARITY_EN
  assign parity = ^q_vec;
`endif

endmodule

// File: tb/tb_lab4_univ_shift_reg.sv
// tb/tb_lab4_univ_shift_reg.sv - scoreboard bench for lab4_univ_shift_reg (WIDTH=4, falling-edge active)
module tb_lab4_univ_shift_reg;
  import lab4_pkg::*;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic       busy;
    logic       done;
    bit         at_rise;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic       clock = 1'b1;
  logic       reset_b;
  logic       ser_in_r, ser_in_l;
  logic [3:0] par_in;
  logic [3:0] Q, NQ;
`ifdef LAB4_SHREG_PARITY_EN
  logic       parity;
`endif

  lab4_univ_shift_reg_if #(.WIDTH(4)) tb_if ();

  lab4_univ_shift_reg #(.WIDTH(4), .NEG_EDGE(1)) dut (
    .clock    (clock),
    .reset_b  (reset_b),
    .mode     (tb_if.mode),
    .rotate   (tb_if.rotate),
    .ser_in_r (ser_in_r),
    .ser_in_l (ser_in_l),
    .par_in   (par_in),
    .start    (tb_if.start),
    .n_shifts (tb_if.n_shifts),
    .Q        (Q),
    .NQ       (NQ),
    .busy     (tb_if.busy),
    .done     (tb_if.done)
`ifdef LAB4_SHREG_PARITY_EN
    ,.parity  (parity)
`endif
  );

  always #5 clock = ~clock;

  task automatic push(input string name, input logic [3:0] q, input logic b, input logic d,
                      input bit at_rise);
    exp_t e;
    e.name = name; e.q = q; e.busy = b; e.done = d; e.at_rise = at_rise;
    sb.push_back(e);
  endtask

  task automatic set_in(input logic [1:0] m, input logic rot, input logic sr, input logic sl,
                        input logic [3:0] par, input logic st, input logic [2:0] n);
    tb_if.mode = m; tb_if.rotate = rot; ser_in_r = sr; ser_in_l = sl;
    par_in = par; tb_if.start = st; tb_if.n_shifts = n;
  endtask

  // Drive just after a rising edge; expect the result after the next falling edge.
  task automatic step(input string name, input logic [1:0] m, input logic rot, input logic sr,
                      input logic sl, input logic [3:0] par, input logic st, input logic [2:0] n,
                      input logic [3:0] eq, input logic eb, input logic ed);
    @(posedge clock);
    #1;
    set_in(m, rot, sr, sl, par, st, n);
    push(name, eq, eb, ed, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    logic bad;
    forever begin
      @(clock);
      #2;
      if (sb.size() > 0 && sb[0].at_rise == clock) begin
        e = sb.pop_front();
        n_vec++;
        bad = (Q !== e.q) || (NQ !== ~e.q) || (tb_if.busy !== e.busy) || (tb_if.done !== e.done);
`ifdef LAB4_SHREG_PARITY_EN
        bad = bad || (parity !== ^e.q);
`endif
        if (bad) begin
          n_err++;
          $display("FAIL %s: got Q=%b NQ=%b busy=%b done=%b, expected Q=%b NQ=%b busy=%b done=%b",
                   e.name, Q, NQ, tb_if.busy, tb_if.done, e.q, ~e.q, e.busy, e.done);
        end
      end
    end
  end

  initial begin : stim
    reset_b = 1'b0;
    set_in(2'b00, 0, 0, 0, 4'b0000, 0, 3'd0);
    push("reset", 4'b0000, 0, 0, 1'b1);
    @(posedge clock);
    @(posedge clock);
    #1 reset_b = 1'b1;

    step("load_1011", 2'b11, 0, 0, 0, 4'b1011, 0, 3'd0, 4'b1011, 0, 0);
    @(negedge clock);
    #1 par_in = 4'b0101;
    push("rise_no_change", 4'b1011, 0, 0, 1'b1);
    step("shr_ser1",  2'b01, 0, 1, 0, 4'b0000, 0, 3'd0, 4'b1101, 0, 0);
    step("reload1",   2'b11, 0, 0, 0, 4'b1011, 0, 3'd0, 4'b1011, 0, 0);
    step("shl_ser0",  2'b10, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b0110, 0, 0);
    step("reload2",   2'b11, 0, 0, 0, 4'b1011, 0, 3'd0, 4'b1011, 0, 0);
    step("rotr",      2'b01, 1, 0, 0, 4'b0000, 0, 3'd0, 4'b1101, 0, 0);
    step("rotl",      2'b10, 1, 0, 0, 4'b0000, 0, 3'd0, 4'b1011, 0, 0);
    step("hold",      2'b00, 0, 1, 1, 4'b1111, 0, 3'd0, 4'b1011, 0, 0);

    step("load_1000", 2'b11, 0, 0, 0, 4'b1000, 0, 3'd0, 4'b1000, 0, 0);
    step("b_start",   2'b01, 1, 0, 0, 4'b0000, 1, 3'd3, 4'b1000, 1, 0);
    step("b_s1",      2'b11, 0, 0, 0, 4'b1111, 1, 3'd0, 4'b0100, 1, 0);
    step("b_s2",      2'b11, 0, 0, 1, 4'b1111, 1, 3'd3, 4'b0010, 1, 0);
    step("b_s3_done", 2'b11, 0, 0, 0, 4'b1111, 1, 3'd2, 4'b0001, 0, 1);
    step("b_done_ign",2'b01, 0, 1, 0, 4'b1111, 1, 3'd2, 4'b0001, 0, 0);
    step("b_idle",    2'b00, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b0001, 0, 0);

    step("ab_load",   2'b11, 0, 0, 0, 4'b1000, 0, 3'd0, 4'b1000, 0, 0);
    step("ab_start",  2'b01, 1, 0, 0, 4'b0000, 1, 3'd3, 4'b1000, 1, 0);
    step("ab_s1",     2'b00, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b0100, 1, 0);
    step("ab_s2",     2'b00, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b0010, 1, 0);
    @(posedge clock);
    #1 reset_b = 1'b0;
    push("abort_rst",     4'b0000, 0, 0, 1'b1);
    push("abort_no_done", 4'b0000, 0, 0, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #1 reset_b = 1'b1;
    step("post_abort",2'b00, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b0000, 0, 0);

    step("st_n0_load",2'b11, 0, 0, 0, 4'b0110, 1, 3'd0, 4'b0110, 0, 0);
    step("st_ld_mode",2'b11, 0, 0, 0, 4'b1001, 1, 3'd2, 4'b1001, 0, 0);
    step("rotl2",     2'b10, 1, 1, 0, 4'b0000, 0, 3'd0, 4'b0011, 0, 0);
    step("n6_start",  2'b10, 0, 0, 0, 4'b0000, 1, 3'd6, 4'b0011, 1, 0);
    step("n6_s1",     2'b11, 0, 0, 0, 4'b1111, 1, 3'd0, 4'b0110, 1, 0);
    step("n6_s2",     2'b11, 0, 0, 0, 4'b1111, 1, 3'd0, 4'b1100, 1, 0);
    step("n6_s3",     2'b11, 0, 0, 0, 4'b1111, 1, 3'd0, 4'b1000, 1, 0);
    step("n6_s4_done",2'b11, 0, 0, 0, 4'b1111, 1, 3'd0, 4'b0000, 0, 1);
    step("n6_idle",   2'b01, 0, 1, 0, 4'b1111, 1, 3'd2, 4'b0000, 0, 0);
    step("final_hold",2'b00, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b0000, 0, 0);

    repeat (2) @(posedge clock);
    #3;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
